// File: rtl/fp_add_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fp_add_arbiter (with ieee754_adder)
// Purpose  : Round-robin sharing of one combinational FP adder among
//            NUM_REQ requesters, with a backpressured result port.
// Revision : 1.0 - initial release
// ============================================================================

module ieee754_adder (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);

    logic [7:0]  w_ea;
    logic [7:0]  w_eb;
    logic [23:0] w_ma;
    logic [23:0] w_mb;
    logic [7:0]  w_e_big;
    logic [7:0]  w_e_small;
    logic [23:0] w_m_big;
    logic [23:0] w_m_small;
    logic [7:0]  w_diff;
    logic [23:0] w_m_shift;
    logic [24:0] w_m_sum;
    logic [8:0]  w_e_res;
    logic [22:0] w_frac;

    // Operands are treated as positive; denormals use effective exponent 1.
    always_comb begin
        w_ea = (i_a[30:23] == 8'd0) ? 8'd1 : i_a[30:23];
        w_eb = (i_b[30:23] == 8'd0) ? 8'd1 : i_b[30:23];
        w_ma = {|i_a[30:23], i_a[22:0]};
        w_mb = {|i_b[30:23], i_b[22:0]};
        if (w_ea >= w_eb) begin
            w_e_big   = w_ea;
            w_e_small = w_eb;
            w_m_big   = w_ma;
            w_m_small = w_mb;
        end else begin
            w_e_big   = w_eb;
            w_e_small = w_ea;
            w_m_big   = w_mb;
            w_m_small = w_ma;
        end
        w_diff    = w_e_big - w_e_small;
        w_m_shift = (w_diff > 8'd23) ? 24'd0 : (w_m_small >> w_diff);
        w_m_sum   = {1'b0, w_m_big} + {1'b0, w_m_shift};
        if (w_m_sum[24]) begin
            w_e_res = {1'b0, w_e_big} + 9'd1;
            w_frac  = w_m_sum[23:1];
        end else if (!w_m_sum[23]) begin
            w_e_res = 9'd0;
            w_frac  = w_m_sum[22:0];
        end else begin
            w_e_res = {1'b0, w_e_big};
            w_frac  = w_m_sum[22:0];
        end
        o_sum = (w_e_res >= 9'd255) ? 32'h7F80_0000 : {1'b0, w_e_res[7:0], w_frac};
    end

endmodule

module fp_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [31:0]             res_data,
    output logic [ID_W-1:0]         res_id,
    output logic                    busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_id;
    logic [31:0]        r_op_a;
    logic [31:0]        r_op_b;
    logic [31:0]        r_res_data;
    logic [ID_W-1:0]    r_res_id;
    logic               r_res_valid;

    logic [ID_W-1:0]    w_grant;
    logic [ID_W-1:0]    w_ptr_next;
    logic [NUM_REQ-1:0] w_onehot;
    logic               w_any;
    logic [31:0]        w_sel_a;
    logic [31:0]        w_sel_b;
    logic [31:0]        w_sum;
    int                 w_dist;
    int                 w_best;

    // Winner is the valid requester at the smallest rotated distance from rr_ptr.
    always_comb begin
        w_grant  = '0;
        w_onehot = '0;
        w_any    = 1'b0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_dist   = 0;
        w_best   = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = i - int'(r_rr_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + NUM_REQ;
            end
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_grant     = ID_W'(i);
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
                w_any       = 1'b1;
                w_sel_a     = req_a[32*i +: 32];
                w_sel_b     = req_b[32*i +: 32];
            end
        end
    end

    assign w_ptr_next = (w_grant == ID_W'(NUM_REQ-1)) ? '0 : w_grant + ID_W'(1);

    ieee754_adder u_adder (
        .i_a   (r_op_a),
        .i_b   (r_op_b),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_res_data  <= '0;
            r_res_id    <= '0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_op_a   <= w_sel_a;
                        r_op_b   <= w_sel_b;
                        r_id     <= w_grant;
                        r_rr_ptr <= w_ptr_next;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_res_data  <= w_sum;
                    r_res_id    <= r_id;
                    r_res_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE) ? w_onehot : '0;
    assign busy      = (r_state != S_IDLE);
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;

endmodule

`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fp_add_arbiter
// Purpose  : Directed and randomized checks of fp_add_arbiter against a
//            transaction-level arbitration and exact-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_fp_add_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [32*N-1:0]  req_a;
    logic [32*N-1:0]  req_b;
    logic [N-1:0]     req_ready;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [IDW-1:0]   res_id;
    logic             busy;

    int          checks = 0;
    int          errors = 0;
    int          m_ptr  = 0;
    int          last_id;
    logic [31:0] last_data;
    logic [31:0] ra [N];
    logic [31:0] rb [N];

    fp_add_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] onehot(input int g);
        logic [31:0] v;
        v    = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    function automatic int model_grant(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // Exact sum of the magnitudes, truncated to 24 significant bits.
    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, emin, p;
        logic [127:0] s;
        ea   = int'(a[30:23]);
        eb   = int'(b[30:23]);
        emin = (ea < eb) ? ea : eb;
        s    = (128'({1'b1, a[22:0]}) << (ea - emin)) + (128'({1'b1, b[22:0]}) << (eb - emin));
        p    = 0;
        for (int i = 0; i < 128; i++) begin
            if (s[i]) p = i;
        end
        s = s >> (p - 23);
        return {1'b0, 8'(emin + p - 23), s[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v[31]    = 1'($urandom_range(0, 1));
        v[30:23] = 8'($urandom_range(100, 150));
        v[22:0]  = 23'($urandom);
        return v;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = ra[i];
            req_b[32*i +: 32] = rb[i];
        end
    endtask

    task automatic run_txn(input logic [N-1:0] mask, input int stall);
        int g;
        logic [31:0] exp_d;
        g     = model_grant(mask);
        exp_d = fp_model(ra[g], rb[g]);
        drive_ops();
        req_valid = mask;
        #1;
        check("grant", 32'(req_ready), onehot(g));
        tick();
        req_valid = '0;
        m_ptr     = (g + 1) % N;
        check("calc_busy", 32'(busy), 32'd1);
        check("calc_valid", 32'(res_valid), 32'd0);
        check("calc_ready", 32'(req_ready), 32'd0);
        res_ready = (stall == 0);
        tick();
        check("res_valid", 32'(res_valid), 32'd1);
        check("res_data", res_data, exp_d);
        check("res_id", 32'(res_id), 32'(g));
        last_id   = int'(res_id);
        last_data = res_data;
        for (int s = 0; s < stall; s++) begin
            req_valid = mask;
            #1;
            check("hold_ready", 32'(req_ready), 32'd0);
            tick();
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_data", res_data, exp_d);
            check("hold_id", 32'(res_id), 32'(g));
        end
        res_ready = 1'b1;
        tick();
        check("done_valid", 32'(res_valid), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        if (stall > 0) begin
            check("regrant", 32'(req_ready), onehot(model_grant(mask)));
        end
        req_valid = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_data", res_data, 32'd0);
        check("rst_id", 32'(res_id), 32'd0);
        tick();
        tick();
        rst   = 1'b0;
        m_ptr = 0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            ra[i] = '0;
            rb[i] = '0;
        end
        do_reset();

        // Single request: 1.0 + 2.0
        ra[0] = 32'h3F80_0000;
        rb[0] = 32'h4000_0000;
        run_txn(4'b0001, 0);
        check("single_data", last_data, 32'h4040_0000);
        check("single_id", 32'(last_id), 32'd0);

        // Round robin from a fresh pointer with all requesters valid
        do_reset();
        ra[1] = 32'h3FC0_0000; rb[1] = 32'h3FC0_0000;
        ra[2] = 32'h3F00_0000; rb[2] = 32'h3F00_0000;
        ra[3] = 32'h4080_0000; rb[3] = 32'h4080_0000;
        run_txn(4'b1111, 0);
        check("rr_0", 32'(last_id), 32'd0);
        run_txn(4'b1111, 0);
        check("rr_1", 32'(last_id), 32'd1);
        check("rr_1_data", last_data, 32'h4040_0000);
        run_txn(4'b1111, 0);
        check("rr_2", 32'(last_id), 32'd2);
        check("rr_2_data", last_data, 32'h3F80_0000);
        run_txn(4'b1111, 0);
        check("rr_3", 32'(last_id), 32'd3);
        check("rr_3_data", last_data, 32'h4100_0000);

        // After 3 was served, 0 beats 3
        run_txn(4'b1001, 0);
        check("wrap_0", 32'(last_id), 32'd0);

        // Backpressure for five cycles with requests pending
        run_txn(4'b0110, 5);

        // Reset during CALC with requester 2 in flight
        for (int i = 0; i < N; i++) begin
            ra[i] = rand_fp();
            rb[i] = rand_fp();
        end
        drive_ops();
        req_valid = 4'b0100;
        #1;
        check("mid_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        check("mid_busy", 32'(busy), 32'd1);
        do_reset();
        for (int c = 0; c < 4; c++) begin
            tick();
            check("post_rst_valid", 32'(res_valid), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
        end
        run_txn(4'b1100, 0);
        check("post_rst_grant", 32'(last_id), 32'd2);

        // Idle: pointer must not move
        req_valid = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_ready", 32'(req_ready), 32'd0);
            check("idle_valid", 32'(res_valid), 32'd0);
        end
        run_txn(4'b1111, 0);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                ra[i] = rand_fp();
                rb[i] = rand_fp();
            end
            run_txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
